vr_vc_converter: RTL and testbench

Valid/ready to valid/credit transmitter bridge; the sending end of a valid/credit link.
- Accepts a valid/ready stream from local logic.
- Forwards each beat as a single-cycle valid pulse on the credit-controlled link.
- Consumes one credit per beat; returned credits arrive as single-cycle pulses from the far-end receiver.
- Sits at the producer side of every credit link; the far end performs the vc-to-vr conversion.

---
 rtl/vc_pkg.sv | 14 +
 rtl/vc_credit_counter.sv | 49 ++++
 rtl/vr_vc_converter.sv | 63 ++++++
 tb/tb_vr_vc_converter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the valid/credit link (transmitter and receiver sides).
package vc_pkg;

  // Counter width able to hold 0..credit_num inclusive.
  function automatic int unsigned cnt_width(input int unsigned credit_num);
    return $clog2(credit_num + 1);
  endfunction

  // A credit arriving at a full counter with no consuming beat is an overflow.
  function automatic logic credit_overflow(input logic inc, input logic dec, input logic full);
    return inc & ~dec & full;
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Saturating credit counter with sticky overflow flag.
module vc_credit_counter
  import vc_pkg::*;
#(
  parameter int unsigned CREDIT_NUM = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                inc,
  input  logic                                dec,
  output logic [cnt_width(CREDIT_NUM)-1:0]    count,
  output logic                                nonzero,
  output logic                                overflow
);

  localparam int unsigned CntW = cnt_width(CREDIT_NUM);
  typedef logic [CntW-1:0] credit_cnt_t;
  localparam credit_cnt_t Full = credit_cnt_t'(CREDIT_NUM);

  credit_cnt_t count_q, count_d;
  logic        err_q, err_d;
  logic        ovf;

  // Next count: add returned credit, subtract consumed one, hold at full on overflow.
  always_comb begin
    ovf     = credit_overflow(inc, dec, count_q == Full);
    count_d = count_q;
    err_d   = err_q | ovf;
    if (!ovf) begin
      count_d = count_q + credit_cnt_t'(inc) - credit_cnt_t'(dec);
    end
  end

  // Counter and sticky error registers; reset dominates any incoming credit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign overflow = err_q;

endmodule

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit transmitter bridge.
// Optional macro VR_VC_CREDIT_FWD_EN: a credit arriving at an empty counter is
// consumed in the same cycle, adding a combinational m_credit_i -> s_ready_o path.
module vr_vc_converter
  import vc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CREDIT_NUM = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            s_data_i,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic                             m_valid_o,
  input  logic                             m_credit_i,
  output logic [cnt_width(CREDIT_NUM)-1:0] credit_cnt_o,
  output logic                             credit_err_o
);

  logic                  cnt_nonzero;
  logic                  send;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;

`ifdef VR_VC_CREDIT_FWD_EN
  assign s_ready_o = cnt_nonzero | m_credit_i;
`else
  assign s_ready_o = cnt_nonzero;
`endif

  assign send = s_valid_i & s_ready_o;

  vc_credit_counter #(
    .CREDIT_NUM (CREDIT_NUM)
  ) u_credit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (m_credit_i),
    .dec      (send),
    .count    (credit_cnt_o),
    .nonzero  (cnt_nonzero),
    .overflow (credit_err_o)
  );

  // Output stage: one-cycle valid pulse per accepted beat; data holds between beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= send;
      if (send) begin
        m_data_q <= s_data_i;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;

endmodule

// File: tb/tb_vr_vc_converter.sv
// Scoreboard bench for vr_vc_converter: directed test-plan sequences then random traffic.
module tb_vr_vc_converter;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned CREDIT_NUM = 2;
  localparam int unsigned CntW       = $clog2(CREDIT_NUM + 1);

  logic                  clk;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_credit_i;
  logic [CntW-1:0]       credit_cnt_o;
  logic                  credit_err_o;

  vr_vc_converter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CREDIT_NUM (CREDIT_NUM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_credit_i   (m_credit_i),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    logic        err;
  } status_t;

  int unsigned           n_vec  = 0;
  int unsigned           n_err  = 0;
  logic [DATA_WIDTH-1:0] data_q[$];
  status_t               stat_q[$];

  // Reference state: credits held and sticky error, as plain integers.
  int unsigned           m_credits = 0;
  logic                  m_err     = 1'b0;
  logic [DATA_WIDTH-1:0] last_data = '0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One link cycle: drive inputs, check readiness, record expected outcome.
  task automatic cyc(input logic r, input logic v, input logic [DATA_WIDTH-1:0] d,
                     input logic c, output logic sent);
    logic    rdy;
    status_t s;
    @(negedge clk);
    rst_n      = r;
    s_valid_i  = v;
    s_data_i   = d;
    m_credit_i = c;
    #1;
`ifdef VR_VC_CREDIT_FWD_EN
    rdy = (m_credits != 0) || c;
`else
    rdy = (m_credits != 0);
`endif
    check("s_ready", s_ready_o, rdy);
    sent = r && v && rdy;
    if (!r) begin
      m_credits = 0;
      m_err     = 1'b0;
    end else if (c && !sent && m_credits == CREDIT_NUM) begin
      m_err = 1'b1;
    end else begin
      m_credits = m_credits + (c ? 1 : 0) - (sent ? 1 : 0);
    end
    if (sent) data_q.push_back(d);
    s.cnt = m_credits;
    s.err = m_err;
    stat_q.push_back(s);
  endtask

  // Monitor: every valid pulse must carry the beat accepted the cycle before.
  always @(posedge clk) begin
    logic [DATA_WIDTH-1:0] exp_d;
    status_t               s;
    #1;
    if (stat_q.size() != 0) begin
      s = stat_q.pop_front();
      check("credit_cnt", credit_cnt_o, s.cnt);
      check("credit_err", credit_err_o, s.err);
      if (data_q.size() != 0) begin
        exp_d = data_q.pop_front();
        last_data = exp_d;
        check("m_valid", m_valid_o, 1);
        check("m_data", m_data_o, exp_d);
      end else begin
        check("m_valid", m_valid_o, 0);
        check("m_data_hold", m_data_o, last_data);
      end
    end
  end

  initial begin
    logic                  sent;
    logic                  cur_v;
    logic [DATA_WIDTH-1:0] cur_d;
    logic                  c;
    logic                  r;
    rst_n = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_credit_i = 1'b0;

    // Reset, then no credits: beat 0xA5 must stall.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, sent);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, sent);
    last_data = '0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'hA5, 1'b0, sent);

    // Two credits, three beats; third waits for the next credit.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, sent);
    cyc(1'b1, 1'b1, 8'h11, 1'b0, sent);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, sent);
    cyc(1'b1, 1'b1, 8'h33, 1'b0, sent);
    cyc(1'b1, 1'b1, 8'h33, 1'b1, sent);
    if (!sent) cyc(1'b1, 1'b1, 8'h33, 1'b0, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);

    // cnt=1 with simultaneous send and credit.
    cyc(1'b1, 1'b0, 8'h00, 1'b1, sent);
    cyc(1'b1, 1'b1, 8'h44, 1'b1, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);

    // Fill, then overflow; error must stick.
    cyc(1'b1, 1'b0, 8'h00, 1'b1, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, sent);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);

    // Reset while a pulse is pending and cnt=1.
    cyc(1'b1, 1'b1, 8'h55, 1'b0, sent);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, sent);
    last_data = '0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);

    // Empty counter, beat 0x5C waiting, one credit arrives.
    cyc(1'b1, 1'b1, 8'h5C, 1'b1, sent);
    if (!sent) cyc(1'b1, 1'b1, 8'h5C, 1'b0, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);

    // Random traffic; held data stays stable until accepted.
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!cur_v) begin
        cur_v = ($urandom_range(0, 2) != 0);
        cur_d = DATA_WIDTH'($urandom);
      end
      c = (($urandom_range(0, 2) == 0) && (m_credits < CREDIT_NUM)) ||
          ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 299) != 0);
      cyc(r, cur_v, cur_d, c, sent);
      if (!r) last_data = '0;
      if (sent) cur_v = 1'b0;
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, sent);
    @(negedge clk);
    check("leftover_beats", data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
